// File: rtl/pipeline_muldiv_unit_if.sv
// Request/response channels between the EXA issue side and the iterative mul/div unit.
interface pipeline_muldiv_unit_if #(
    parameter int unsigned XLEN = 64
);
    logic            req_valid;
    logic            req_ready;
    logic [3:0]      req_op;
    logic [XLEN-1:0] req_a;
    logic [XLEN-1:0] req_b;
    logic [4:0]      req_rd;
    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] resp_result;
    logic [4:0]      resp_rd;

    modport master (
        output req_valid, req_op, req_a, req_b, req_rd, resp_ready,
        input  req_ready, resp_valid, resp_result, resp_rd
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_rd, resp_ready,
        output req_ready, resp_valid, resp_result, resp_rd
    );
endinterface

// File: rtl/pipeline_muldiv_unit.sv
// Iterative RV64M multiply/divide engine: one result bit per cycle, valid/ready
// request and response channels, flush abort, busy stall to the pipeline.
module pipeline_muldiv_unit #(
    parameter int unsigned XLEN = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    output logic                   busy,
    pipeline_muldiv_unit_if.slave  bus
);
    localparam int unsigned HALF = XLEN / 2;
    localparam int unsigned CW   = $clog2(XLEN + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [2*XLEN-1:0] acc;       // product (MUL) or partial remainder in the low half (DIV)
    logic [XLEN-1:0]   shreg;     // multiplier bits (MUL) or dividend/quotient bits (DIV), MSB first
    logic [XLEN-1:0]   opnd;      // multiplicand (MUL) or divisor (DIV) magnitude
    logic [2:0]        op_q;
    logic              w_q;
    logic              sgn_q;     // product / quotient must be negated
    logic              sgn_r;     // remainder must be negated
    logic [XLEN-1:0]   result_q;
    logic [4:0]        rd_q;

    // Request-side decode and operand preparation
    logic [2:0]      op_f;
    logic            w_eff;
    logic            a_signed;
    logic            b_signed;
    logic [XLEN-1:0] a_ext;
    logic [XLEN-1:0] b_ext;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic [XLEN-1:0] min_val;
    logic            div_zero;
    logic            div_ovf;
    logic [XLEN-1:0] special_res;

    // Iteration step and final result formation
    logic [2*XLEN-1:0] mul_acc_nx;
    logic [XLEN:0]     trial;
    logic [XLEN:0]     diff;
    logic              ge;
    logic [XLEN-1:0]   rem_nx;
    logic [XLEN-1:0]   quo_nx;
    logic [2*XLEN-1:0] acc_nx;
    logic [XLEN-1:0]   shreg_nx;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo_s;
    logic [XLEN-1:0]   rem_s;
    logic [XLEN-1:0]   raw_res;
    logic [XLEN-1:0]   final_res;

    function automatic logic [XLEN-1:0] sext_half(input logic [HALF-1:0] v);
        return {{HALF{v[HALF-1]}}, v};
    endfunction

    function automatic logic [XLEN-1:0] zext_half(input logic [HALF-1:0] v);
        return {{HALF{1'b0}}, v};
    endfunction

    assign bus.req_ready   = (state == S_IDLE);
    assign bus.resp_valid  = (state == S_DONE);
    assign busy            = (state != S_IDLE);
    assign bus.resp_result = result_q;
    assign bus.resp_rd     = rd_q;

    // Decode the request, convert operands to sign + magnitude, detect the 1-cycle divide cases
    always_comb begin
        op_f     = bus.req_op[2:0];
        // the W bit only exists for MUL and the divide group
        w_eff    = bus.req_op[3] & (op_f[2] | (op_f[1:0] == 2'b00));
        a_signed = (op_f == 3'd0) | (op_f == 3'd1) | (op_f == 3'd2) | (op_f == 3'd4) | (op_f == 3'd6);
        b_signed = (op_f == 3'd0) | (op_f == 3'd1) | (op_f == 3'd4) | (op_f == 3'd6);

        a_ext = bus.req_a;
        b_ext = bus.req_b;
        if (w_eff) begin
            a_ext = a_signed ? sext_half(bus.req_a[HALF-1:0]) : zext_half(bus.req_a[HALF-1:0]);
            b_ext = b_signed ? sext_half(bus.req_b[HALF-1:0]) : zext_half(bus.req_b[HALF-1:0]);
        end

        a_neg = a_signed & a_ext[XLEN-1];
        b_neg = b_signed & b_ext[XLEN-1];
        a_mag = a_neg ? -a_ext : a_ext;
        b_mag = b_neg ? -b_ext : b_ext;

        min_val  = w_eff ? {{(HALF+1){1'b1}}, {(HALF-1){1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
        div_zero = op_f[2] & (b_ext == '0);
        div_ovf  = op_f[2] & ~op_f[0] & (a_ext == min_val) & (b_ext == '1);

        if (div_zero)
            special_res = op_f[1] ? (w_eff ? sext_half(bus.req_a[HALF-1:0]) : bus.req_a) : '1;
        else
            special_res = op_f[1] ? '0 : a_ext;
    end

    // One shift-add or restoring-divide step, plus the signed/W-adjusted result of the last step
    always_comb begin
        mul_acc_nx = (acc << 1) + (shreg[XLEN-1] ? {{XLEN{1'b0}}, opnd} : '0);

        trial  = {acc[XLEN-1:0], shreg[XLEN-1]};
        diff   = trial - {1'b0, opnd};
        // partial remainder stays below the divisor, so bit XLEN of diff is a pure borrow
        ge     = ~diff[XLEN];
        rem_nx = ge ? diff[XLEN-1:0] : trial[XLEN-1:0];
        quo_nx = {shreg[XLEN-2:0], ge};

        if (op_q[2]) begin
            acc_nx   = {{XLEN{1'b0}}, rem_nx};
            shreg_nx = quo_nx;
        end else begin
            acc_nx   = mul_acc_nx;
            shreg_nx = shreg << 1;
        end

        prod  = sgn_q ? -mul_acc_nx : mul_acc_nx;
        quo_s = sgn_q ? -quo_nx : quo_nx;
        rem_s = sgn_r ? -rem_nx : rem_nx;

        if (op_q[2])
            raw_res = op_q[1] ? rem_s : quo_s;
        else if (op_q[1:0] == 2'b00)
            raw_res = prod[XLEN-1:0];
        else
            raw_res = prod[2*XLEN-1:XLEN];

        final_res = w_q ? sext_half(raw_res[HALF-1:0]) : raw_res;
    end

    // Control FSM and iterative datapath registers; flush overrides everything
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            acc      <= '0;
            shreg    <= '0;
            opnd     <= '0;
            op_q     <= '0;
            w_q      <= 1'b0;
            sgn_q    <= 1'b0;
            sgn_r    <= 1'b0;
            result_q <= '0;
            rd_q     <= '0;
        end else if (flush) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        op_q <= op_f;
                        w_q  <= w_eff;
                        rd_q <= bus.req_rd;
                        if (div_zero | div_ovf) begin
                            result_q <= special_res;
                            state    <= S_DONE;
                        end else begin
                            state <= S_BUSY;
                            cnt   <= w_eff ? CW'(HALF) : CW'(XLEN);
                            acc   <= '0;
                            sgn_q <= a_neg ^ b_neg;
                            sgn_r <= a_neg;
                            opnd  <= op_f[2] ? b_mag : a_mag;
                            // W ops park their 32 significant bits at the top so both widths consume MSB first
                            if (w_eff)
                                shreg <= (op_f[2] ? a_mag : b_mag) << HALF;
                            else
                                shreg <= op_f[2] ? a_mag : b_mag;
                        end
                    end
                end
                S_BUSY: begin
                    acc   <= acc_nx;
                    shreg <= shreg_nx;
                    cnt   <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        result_q <= final_res;
                        state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.resp_ready)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
